// File: rtl/tiny_proc_demo_pkg.sv
// rtl/tiny_proc_demo_pkg.sv - shared types and 7-segment table for the tiny processor demo
package tiny_proc_demo_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_DONE,
    ST_SEL_HI,
    ST_SETTLE_HI,
    ST_SAMPLE_HI,
    ST_SEL_LO,
    ST_SETTLE_LO,
    ST_SAMPLE_LO,
    ST_EMIT,
    ST_FINISH
  } dump_state_e;

  localparam int DEF_SETTLE = 4;

  // Index is the hex digit, value is the active-high pattern (bit0=a .. bit6=g).
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 7-segment pattern to hex nibble decoder
module seg7_decode
  import tiny_proc_demo_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  // Unknown patterns fall through as nibble 0 with valid low.
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_dump_sequencer.sv
// rtl/mem_dump_sequencer.sv - walks the processor display selects and streams recovered memory bytes
module mem_dump_sequencer
  import tiny_proc_demo_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              done_i,
  input  logic [6:0]        seg_i,
  output logic              display_on_o,
  output logic              lsb_sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic [ADDR_W-1:0] byte_addr_o,
  output logic [7:0]        byte_data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  dump_state_e       state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        hi, lo;
  logic              err;
  logic [3:0]        dec_nibble;
  logic              dec_valid;

  seg7_decode u_decode (
    .seg    (seg_i),
    .nibble (dec_nibble),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (start_i) state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_i) state_nx = ST_SEL_HI;
      ST_SEL_HI:    state_nx = ST_SETTLE_HI;
      ST_SETTLE_HI: if (cnt == '0) state_nx = ST_SAMPLE_HI;
      ST_SAMPLE_HI: state_nx = ST_SEL_LO;
      ST_SEL_LO:    state_nx = ST_SETTLE_LO;
      ST_SETTLE_LO: if (cnt == '0) state_nx = ST_SAMPLE_LO;
      ST_SAMPLE_LO: state_nx = ST_EMIT;
      ST_EMIT: begin
        if (byte_ready_i) state_nx = (addr == LAST_ADDR) ? ST_FINISH : ST_SEL_HI;
      end
      ST_FINISH:    state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // The address never wraps: the last accepted byte leaves addr at LAST_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      addr <= '0;
      hi   <= 4'h0;
      lo   <= 4'h0;
      err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr <= '0;
            err  <= 1'b0;
          end
        end
        ST_SEL_HI, ST_SEL_LO:       cnt <= SETTLE_LOAD;
        ST_SETTLE_HI, ST_SETTLE_LO: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        ST_SAMPLE_HI: begin
          hi <= dec_nibble;
          if (!dec_valid) err <= 1'b1;
        end
        ST_SAMPLE_LO: begin
          lo <= dec_nibble;
          if (!dec_valid) err <= 1'b1;
        end
        ST_EMIT: begin
          if (byte_ready_i && addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Selects are pure functions of state, so they move only when the state changes.
  assign display_on_o = state inside {ST_SEL_HI, ST_SETTLE_HI, ST_SAMPLE_HI, ST_SEL_LO,
                                      ST_SETTLE_LO, ST_SAMPLE_LO, ST_EMIT};
  assign lsb_sel_o    = state inside {ST_SEL_LO, ST_SETTLE_LO, ST_SAMPLE_LO, ST_EMIT};
  assign addr_o       = display_on_o ? addr : '0;
  assign byte_valid_o = (state == ST_EMIT);
  assign byte_addr_o  = addr;
  assign byte_data_o  = {hi, lo};
  assign busy_o       = (state != ST_IDLE);
  assign err_o        = err;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// tb/tb_mem_dump_sequencer.sv - directed self-checking bench for mem_dump_sequencer
module tb_mem_dump_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic       ready = 1'b0;
  logic       bad_lo9 = 1'b0;
  logic [6:0] seg;
  logic       display_on, lsb_sel, byte_valid, busy, err;
  logic [3:0] addr, byte_addr;
  logic [7:0] byte_data;
  logic [7:0] mem_byte;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_got = 0;
  int         cyc = 0;
  int         base;
  logic       ok;
  logic [3:0] got_addr [64];
  logic [7:0] got_data [64];
  int         got_cyc  [64];

  always #5 clk = ~clk;

  mem_dump_sequencer #(.ADDR_W(4), .SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .done_i       (done),
    .seg_i        (seg),
    .display_on_o (display_on),
    .lsb_sel_o    (lsb_sel),
    .addr_o       (addr),
    .byte_valid_o (byte_valid),
    .byte_ready_i (ready),
    .byte_addr_o  (byte_addr),
    .byte_data_o  (byte_data),
    .busy_o       (busy),
    .err_o        (err)
  );

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Processor model: memory holds A5+i at address i, shown one nibble at a time.
  assign mem_byte = 8'hA5 + {4'h0, addr};
  assign seg = !display_on                        ? 7'h00 :
               (bad_lo9 && addr == 4'd9 && lsb_sel) ? 7'h00 :
               hex_to_seg(lsb_sel ? mem_byte[3:0] : mem_byte[7:4]);

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && byte_valid && ready && n_got < 64) begin
      got_addr[n_got] = byte_addr;
      got_data[n_got] = byte_data;
      got_cyc[n_got]  = cyc;
      n_got = n_got + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_outputs", 32'({busy, display_on, lsb_sel, addr, byte_valid, err, byte_data, byte_addr}), 0);
    rst_n = 1'b1;
    tick();

    // Dump 1: long wait for done, ignored start mid-dump, done dropping mid-dump
    base = n_got;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wait_busy", 32'(busy), 1);
    ok = 1'b1;
    repeat (50) begin
      tick();
      if (display_on !== 1'b0 || addr !== 4'h0) ok = 1'b0;
    end
    check("wait_sel_quiet", 32'(ok), 1);
    done = 1'b1;
    check("sel_before_edge", 32'(display_on), 0);
    tick();
    check("sel_after_done", 32'({display_on, lsb_sel, addr}), 32'({1'b1, 1'b0, 4'h0}));
    for (int k = 0; k < 200 && n_got - base < 3; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 400 && n_got - base < 16; k++) tick();
    check("full_count", 32'(n_got - base), 16);
    check("finish_state", 32'({busy, display_on}), 32'(2'b10));
    tick();
    check("idle_after_finish", 32'(busy), 0);
    check("full_err", 32'(err), 0);
    repeat (20) tick();
    check("no_restart_count", 32'(n_got - base), 16);
    for (int i = 0; i < 16; i++)
      check("full_byte", 32'({got_addr[base+i], got_data[base+i]}), 32'({4'(i), 8'(8'hA5 + i)}));
    check("byte_latency", 32'(got_cyc[base+2] - got_cyc[base+1]), 13);

    // Dump 2: backpressure at addr 3, corrupted low nibble at addr 9
    base = n_got;
    bad_lo9 = 1'b1;
    done = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (byte_valid && byte_addr == 4'd3) break;
      tick();
    end
    ready = 1'b0;
    check("bp_reached", 32'({byte_valid, byte_addr}), 32'({1'b1, 4'd3}));
    check("bp_err_clear", 32'(err), 0);
    ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (byte_valid !== 1'b1 || byte_addr !== 4'd3 || byte_data !== 8'hA8 || addr !== 4'd3) ok = 1'b0;
      tick();
    end
    check("bp_hold", 32'(ok), 1);
    check("bp_no_accept", 32'(n_got - base), 3);
    check("bp_still_valid", 32'(byte_valid), 1);
    ready = 1'b1;
    tick();
    check("bp_accepted", 32'(n_got - base), 4);
    check("bp_byte", 32'({got_addr[base+3], got_data[base+3]}), 32'({4'd3, 8'hA8}));
    for (int k = 0; k < 400 && n_got - base < 16; k++) tick();
    check("bad_count", 32'(n_got - base), 16);
    tick();
    check("bad_err_sticky", 32'(err), 1);
    check("bad_byte9", 32'(got_data[base+9]), 32'h0A0);
    check("bad_byte8", 32'(got_data[base+8]), 32'h0AD);
    check("bad_byte10", 32'(got_data[base+10]), 32'h0AF);
    bad_lo9 = 1'b0;
    repeat (5) tick();
    check("err_held_idle", 32'(err), 1);

    // Dump 3: new start clears err, then reset mid-SETTLE_LO at addr 5
    base = n_got;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_err", 32'(err), 0);
    for (int k = 0; k < 300; k++) begin
      if (display_on && lsb_sel && addr == 4'd5) break;
      tick();
    end
    tick();
    check("pre_rst_count", 32'(n_got - base), 5);
    check("pre_rst_sel", 32'({display_on, lsb_sel, addr, byte_valid}), 32'({1'b1, 1'b1, 4'd5, 1'b0}));
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({busy, display_on, lsb_sel, addr, byte_valid, err, byte_data, byte_addr}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("rst_no_byte", 32'(n_got - base), 5);
    check("rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
